// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs a req/gnt/rvalid access to data memory,
// stalls the pipeline while it is outstanding and formats load data for MEM/WB.
module mem_stage_lsu #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_mem,
  input  logic        store_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] addr_mem,
  input  logic [31:0] wdata_mem,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic [31:0] dm_data_mem,
  output logic        lsu_done,
  output logic        stall_mem,
  output logic        misalign_mem,
  output logic        bus_err_mem,
  output logic [1:0]  dbg_state
);

  // Handshake: dm_req rises with stable we/addr/be/wdata and holds until the
  // cycle dm_gnt is sampled high; read data is taken on dm_rvalid only in WAIT.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        op_load;
  logic [2:0]  op_f3;
  logic [1:0]  op_off;

  logic        access;
  logic        f3_ok;
  logic        aligned;
  logic        fault;
  logic        legal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        timeout;

  always_comb begin
    access = load_mem | store_mem;
    f3_ok  = 1'b0;
    if (load_mem) begin
      case (funct3_mem)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else begin
      case (funct3_mem)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end

    case (funct3_mem[1:0])
      2'b01:   aligned = ~addr_mem[0];
      2'b10:   aligned = (addr_mem[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase

    fault = access & ((load_mem & store_mem) | ~f3_ok | ~aligned);
    legal = access & ~fault;

    case (funct3_mem[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_mem[1:0];
        wdata_c = {4{wdata_mem[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {addr_mem[1], 1'b0};
        wdata_c = {2{wdata_mem[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata_mem;
      end
    endcase
  end

  assign timeout   = (wait_cnt == 8'(MAX_WAIT - 1));
  assign stall_mem = ((state == S_IDLE) & legal) | (state == S_REQ) | (state == S_WAIT);
  assign dbg_state = state;

  function automatic logic [31:0] format_load(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b100:  format_load = {24'd0, b};
      3'b101:  format_load = {16'd0, h};
      default: format_load = w;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wait_cnt     <= 8'd0;
      op_load      <= 1'b0;
      op_f3        <= 3'd0;
      op_off       <= 2'd0;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= 32'd0;
      dm_be        <= 4'd0;
      dm_wdata     <= 32'd0;
      dm_data_mem  <= 32'd0;
      lsu_done     <= 1'b0;
      misalign_mem <= 1'b0;
      bus_err_mem  <= 1'b0;
    end else begin
      lsu_done     <= 1'b0;
      misalign_mem <= 1'b0;
      bus_err_mem  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fault) begin
            misalign_mem <= 1'b1;
          end else if (legal) begin
            op_load  <= load_mem;
            op_f3    <= funct3_mem;
            op_off   <= addr_mem[1:0];
            dm_req   <= 1'b1;
            dm_we    <= store_mem;
            dm_addr  <= {addr_mem[31:2], 2'b00};
            dm_be    <= be_c;
            dm_wdata <= wdata_c;
            wait_cnt <= 8'd0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (dm_gnt && !op_load) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_be    <= 4'd0;
            lsu_done <= 1'b1;
            state    <= S_DONE;
          end else if (timeout) begin
            // A load granted on the last allowed cycle still cannot complete.
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_be       <= 4'd0;
            dm_data_mem <= 32'd0;
            bus_err_mem <= 1'b1;
            lsu_done    <= 1'b1;
            state       <= S_DONE;
          end else if (dm_gnt) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            dm_be  <= 4'd0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (dm_rvalid) begin
            dm_data_mem <= format_load(dm_rdata, op_f3, op_off);
            lsu_done    <= 1'b1;
            state       <= S_DONE;
          end else if (timeout) begin
            dm_data_mem <= 32'd0;
            bus_err_mem <= 1'b1;
            lsu_done    <= 1'b1;
            state       <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
